// File: rtl/if_id_fetch_queue.sv
// if_id_fetch_queue: DEPTH-entry show-ahead queue of {PC+4, instruction} pairs
// between fetch and decode. It replaces the single IF/ID register so that fetch
// can run ahead while decode is stalled.
// Optional feature: define FETCHQ_BYPASS_EN for a 0-cycle path when the queue is empty.
module if_id_fetch_queue #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4,
    parameter logic [INST_W-1:0] NOP_INST = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       stall_i,
    input  logic                       enq_valid_i,
    input  logic [PC_W-1:0]            enq_pc_i,
    input  logic [INST_W-1:0]          enq_inst_i,
    output logic                       enq_ready_o,
    output logic                       deq_valid_o,
    output logic [PC_W-1:0]            deq_pc_o,
    output logic [INST_W-1:0]          deq_inst_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [$clog2(DEPTH):0]     flush_drop_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    // Storage has no reset; only the pointers and count define what is valid.
    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, flush_drop;

    logic queue_valid, bypass, enq_fire, deq_fire, wr_en, rd_en;

    assign queue_valid = (count != CNT_W'(0));
    // Ready depends only on registered state, so PCWrite never sees stall/flush.
    assign enq_ready_o = (count != CNT_W'(DEPTH));

`ifdef FETCHQ_BYPASS_EN
    // Empty queue: hand the incoming entry straight to decode.
    assign bypass = ~queue_valid & enq_valid_i & ~flush_i;
`else
    assign bypass = 1'b0;
`endif

    assign deq_valid_o = queue_valid | bypass;
    assign enq_fire    = enq_valid_i & enq_ready_o;
    assign deq_fire    = deq_valid_o & ~stall_i;
    // A bypassed entry consumed this cycle is never written into the queue.
    assign wr_en       = enq_fire & ~(bypass & ~stall_i);
    assign rd_en       = deq_fire & queue_valid;

    // Head entry (or bypassed entry) to decode; a bubble when nothing is valid.
    always_comb begin
        deq_pc_o   = '0;
        deq_inst_o = NOP_INST;
        if (bypass) begin
            deq_pc_o   = enq_pc_i;
            deq_inst_o = enq_inst_i;
        end else if (queue_valid) begin
            deq_pc_o   = pc_mem[rd_ptr];
            deq_inst_o = inst_mem[rd_ptr];
        end
    end

    // Entry storage write; a flush discards the same-cycle enqueue.
    always_ff @(posedge clk_i) begin
        if (wr_en && !flush_i) begin
            pc_mem[wr_ptr]   <= enq_pc_i;
            inst_mem[wr_ptr] <= enq_inst_i;
        end
    end

    // Pointer/count bookkeeping; flush wins over stall and enqueue.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            flush_drop <= '0;
        end else if (flush_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            flush_drop <= count;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign count_o      = count;
    assign flush_drop_o = flush_drop;

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Directed bench for if_id_fetch_queue (DEPTH=4, NOP_INST=0).
module tb_if_id_fetch_queue;

    localparam int PC_W   = 32;
    localparam int INST_W = 32;
    localparam int DEPTH  = 4;
    localparam logic [31:0] NOP = 32'h0;

    logic        clk = 1'b0;
    logic        rst, flush, stall, enq_valid;
    logic [31:0] enq_pc, enq_inst;
    logic        enq_ready, deq_valid;
    logic [31:0] deq_pc, deq_inst;
    logic [2:0]  count, flush_drop;

    int n_chk = 0;
    int n_err = 0;

    if_id_fetch_queue #(.PC_W(PC_W), .INST_W(INST_W), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .stall_i(stall),
        .enq_valid_i(enq_valid), .enq_pc_i(enq_pc), .enq_inst_i(enq_inst),
        .enq_ready_o(enq_ready), .deq_valid_o(deq_valid), .deq_pc_o(deq_pc),
        .deq_inst_o(deq_inst), .count_o(count), .flush_drop_o(flush_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0; enq_valid = 1'b0;
        enq_pc = '0; enq_inst = '0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();

        // reset / idle
        chk("rst_valid", 64'(deq_valid), 64'd0);
        chk("rst_inst",  64'(deq_inst),  64'(NOP));
        chk("rst_pc",    64'(deq_pc),    64'd0);
        chk("rst_count", 64'(count),     64'd0);
        chk("rst_ready", 64'(enq_ready), 64'd1);
        chk("rst_drop",  64'(flush_drop), 64'd0);

        // single entry pass-through
        enq_valid = 1'b1; enq_pc = 32'h4; enq_inst = 32'h20080005;
`ifdef FETCHQ_BYPASS_EN
        #1;
        chk("byp_valid", 64'(deq_valid), 64'd1);
        chk("byp_inst",  64'(deq_inst),  64'h20080005);
        chk("byp_pc",    64'(deq_pc),    64'h4);
        tick();
        enq_valid = 1'b0;
        chk("byp_count", 64'(count), 64'd0);
        chk("byp_after", 64'(deq_valid), 64'd0);
`else
        #1;
        chk("nobyp_valid", 64'(deq_valid), 64'd0);
        chk("nobyp_inst",  64'(deq_inst),  64'(NOP));
        tick();
        enq_valid = 1'b0;
        chk("one_valid", 64'(deq_valid), 64'd1);
        chk("one_inst",  64'(deq_inst),  64'h20080005);
        chk("one_pc",    64'(deq_pc),    64'h4);
        chk("one_count", 64'(count),     64'd1);
        tick();
        chk("one_empty", 64'(deq_valid), 64'd0);
        chk("one_nop",   64'(deq_inst),  64'(NOP));
`endif

        // fill under stall; 5th held by fetch
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            enq_valid = 1'b1; enq_pc = 32'h100 + 32'(4 * i); enq_inst = 32'hA0000000 + 32'(i);
            if (i < 4) begin
                chk("fill_ready", 64'(enq_ready), 64'd1);
                tick();
            end
        end
        chk("full_count", 64'(count), 64'd4);
        chk("full_ready", 64'(enq_ready), 64'd0);
        tick();
        chk("full_hold_count", 64'(count), 64'd4);
        chk("full_hold_head",  64'(deq_inst), 64'hA0000000);
        // release: drain in order, 5th enters once space frees
        stall = 1'b0;
        for (int j = 0; j < 5; j++) begin
            chk("drain_inst", 64'(deq_inst), 64'hA0000000 + 64'(j));
            chk("drain_pc",   64'(deq_pc),   64'h100 + 64'(4 * j));
            chk("drain_count", 64'(count), (j == 0) ? 64'd4 : (j == 1) ? 64'd3 : 64'(5 - j));
            tick();
            if (j == 1) enq_valid = 1'b0;
        end
        chk("drain_empty", 64'(count), 64'd0);

        // steady state at count=3 with wrap-around
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            enq_valid = 1'b1; enq_pc = 32'h200 + 32'(4 * i); enq_inst = 32'hB0000000 + 32'(i);
            tick();
        end
        stall = 1'b0;
        for (int k = 0; k < 8; k++) begin
            enq_pc = 32'h200 + 32'(4 * (k + 3)); enq_inst = 32'hB0000000 + 32'(k + 3);
            chk("steady_count", 64'(count), 64'd3);
            chk("steady_head",  64'(deq_inst), 64'hB0000000 + 64'(k));
            chk("steady_pc",    64'(deq_pc),   64'h200 + 64'(4 * k));
            tick();
        end
        enq_valid = 1'b0;
        stall = 1'b1;
        chk("steady_end_count", 64'(count), 64'd3);
        chk("steady_end_head",  64'(deq_inst), 64'hB0000008);

        // flush at count=3 with a same-cycle enqueue
        flush = 1'b1; enq_valid = 1'b1; enq_pc = 32'h300; enq_inst = 32'hDEADBEEF;
        tick();
        flush = 1'b0; enq_valid = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_drop",  64'(flush_drop), 64'd3);
        chk("flush_inst",  64'(deq_inst), 64'(NOP));
        chk("flush_valid", 64'(deq_valid), 64'd0);
        tick();
        chk("drop_held", 64'(flush_drop), 64'd3);
        flush = 1'b1;
        repeat (2) tick();
        flush = 1'b0;
        chk("flush_hold_drop", 64'(flush_drop), 64'd0);

        // async reset mid-cycle at count=2
        for (int i = 0; i < 2; i++) begin
            enq_valid = 1'b1; enq_pc = 32'h400 + 32'(4 * i); enq_inst = 32'hC0000000 + 32'(i);
            tick();
        end
        flush = 1'b1; enq_valid = 1'b0;
        tick();
        flush = 1'b0;
        chk("pre_rst_drop", 64'(flush_drop), 64'd2);
        for (int i = 0; i < 2; i++) begin
            enq_valid = 1'b1; enq_pc = 32'h500 + 32'(4 * i); enq_inst = 32'hC1000000 + 32'(i);
            tick();
        end
        enq_valid = 1'b0;
        chk("pre_rst_count", 64'(count), 64'd2);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_valid", 64'(deq_valid), 64'd0);
        chk("arst_inst",  64'(deq_inst), 64'(NOP));
        chk("arst_ready", 64'(enq_ready), 64'd1);
        chk("arst_drop",  64'(flush_drop), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/if_id_fetch_queue.md
Name: if_id_fetch_queue

Overview:
Parametrised successor to the single IF/ID pipeline register. It is a DEPTH-entry show-ahead queue of {PC+4, instruction} pairs between the fetch stage and the decode stage. It supports a decode-side stall (replaces IF_ID_Write), a branch flush, and a NOP bubble on empty. Fetch can therefore run ahead of decode stalls without losing instructions.

Parameters:
PC_W, 32, width of the stored PC+4 value
INST_W, 32, instruction width
DEPTH, 4, number of entries; power of 2, minimum 2
NOP_INST, 0, instruction word presented while the queue is empty or flushed

Ports:
clk_i  input  1  clock; all state updates on its rising edge
rst_i  input  1  asynchronous, active-high reset
flush_i  input  1  branch taken in ID; discard all queued entries
stall_i  input  1  decode cannot accept an entry this cycle (load-use hazard)
enq_valid_i  input  1  fetch presents a valid entry
enq_pc_i  input  PC_W  PC+4 of the fetched instruction
enq_inst_i  input  INST_W  fetched instruction
enq_ready_o  output  1  queue can accept an entry; also drives PCWrite
deq_valid_o  output  1  head entry is valid
deq_pc_o  output  PC_W  head PC+4
deq_inst_o  output  INST_W  head instruction, or NOP_INST when empty
count_o  output  clog2(DEPTH)+1  current occupancy
flush_drop_o  output  clog2(DEPTH)+1  number of entries discarded by the most recent flush

Behaviour:
- ADDR_W = clog2(DEPTH). Write and read pointers are ADDR_W bits and wrap naturally at DEPTH. count is ADDR_W+1 bits, range 0..DEPTH.
- Reset (async, rst_i=1): pointers=0, count=0, flush_drop_o=0. Storage contents are not reset. Outputs then read deq_valid_o=0, deq_inst_o=NOP_INST, deq_pc_o=0, enq_ready_o=1.
- enq_ready_o = (count != DEPTH). It depends only on registered state; there is no combinational path from stall_i or flush_i.
- enq_fire = enq_valid_i & enq_ready_o.
- deq_fire = deq_valid_o & ~stall_i.
- deq_valid_o = (count != 0).
- deq_pc_o/deq_inst_o are combinational from the head entry when count != 0. When count = 0 they are 0 and NOP_INST.
- Default latency: an entry written at edge N is visible on the outputs after edge N (1 cycle).
- Simultaneous enq_fire and deq_fire: both pointers advance and count is unchanged. This is legal at any count except full, where enq_ready_o=0 blocks the enqueue.
- Full (count=DEPTH): enq_valid_i is ignored. Fetch must hold the PC and the instruction.
- Empty with stall_i=1: no state change; outputs remain NOP_INST.
- flush_i=1 at an edge: pointers reset to 0, count=0, flush_drop_o = count before the edge. Any same-cycle enq_fire or deq_fire is discarded. The flush takes priority over stall and enqueue.
- flush_i held for multiple cycles: the queue stays empty. flush_drop_o records 0 on the second and later cycles.
- flush_drop_o is held until the next flush.
- Reset asserted mid-operation: immediate clear, independent of the clock.
- No state machine beyond the pointers and count. States are EMPTY (count=0), PARTIAL, and FULL (count=DEPTH), implied by count.

Optional Feature:
Macro FETCHQ_BYPASS_EN.
- Defined: when count=0, enq_valid_i=1 and flush_i=0:
  - deq_valid_o=1 and the outputs show enq_pc_i/enq_inst_i combinationally (0-cycle latency).
  - If stall_i=0 in that cycle, the entry is consumed directly and is not written; count stays 0.
  - If stall_i=1, the entry is written normally.
- Not defined: strict 1-cycle latency. No combinational path from enq_* to deq_*.

Test Plan:
- Reset, then 3 cycles idle -> deq_valid_o=0, deq_inst_o=NOP_INST (0x00000000), count_o=0, enq_ready_o=1.
- Enqueue inst 0x20080005 with PC 0x4, stall_i=0 -> after 1 edge deq_inst_o=0x20080005, deq_pc_o=0x4. After the next edge the queue is empty again. With the bypass macro, the instruction appears in the same cycle.
- stall_i=1 while enqueueing 5 consecutive instructions (DEPTH=4) -> count_o reaches 4, enq_ready_o=0, and the 5th is held by fetch. Release the stall -> instructions dequeue in order, one per cycle.
- count=3 with simultaneous enqueue and dequeue for 8 cycles -> count_o stays 3 and pointer wrap-around preserves order.
- flush_i at count=3 with enq_valid_i=1 -> next cycle count_o=0, flush_drop_o=3, deq_inst_o=NOP_INST, and the enqueued instruction is lost.
- Assert rst_i asynchronously mid-cycle with count=2 -> outputs clear before the next clock edge.
